operand_entry: RTL and testbench

- Keypad-driven operand capture sequencer for the calculator datapath.
- Accumulates hex digits into operand A, then operand B.
- Presents both 8-bit operands with a valid/ready handshake to the nibble-splitting stage directly downstream, which breaks them into a0/a1/b0/b1.
- Owns entry editing: digit shift-in, backspace, clear, and enter.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/digit_accum.sv | 53 +++++
 rtl/operand_entry.sv | 130 +++++++++++++
 tb/tb_operand_entry.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: key codes, entry states,
// default operand width and a key-classification helper.
package calc_pkg;

   localparam int OP_W_DEF = 8;
   localparam int KEY_W    = 5;

   localparam logic [KEY_W-1:0] KEY_ENTER = 5'h10;
   localparam logic [KEY_W-1:0] KEY_CLEAR = 5'h11;
   localparam logic [KEY_W-1:0] KEY_BKSP  = 5'h12;

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_OUT = 2'd2
   } state_t;

   // Hex digits occupy 0x00-0x0F, so bit 4 clear marks a digit key.
   function automatic logic key_is_digit(input logic [KEY_W-1:0] code);
      return (code[KEY_W-1] == 1'b0);
   endfunction

endpackage

// File: rtl/digit_accum.sv
// Working register and digit counter shared by the A and B entry phases.
// Shifts hex digits in at the LSB end, saturates when full, backspaces toward empty.
module digit_accum
   import calc_pkg::*;
#(
   parameter int OP_W  = OP_W_DEF,
   parameter int NDIG  = OP_W / 4,
   parameter int CNT_W = $clog2(NDIG + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_shift,
   input  logic [3:0]       i_digit,
   input  logic             i_bksp,
   input  logic             i_clear,
   output logic [OP_W-1:0]  o_work,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [OP_W-1:0]  r_work;
   logic [CNT_W-1:0] r_count;
   logic             w_full;
   logic             w_empty;

   assign w_full  = (r_count == CNT_W'(NDIG));
   assign w_empty = (r_count == '0);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values and simulation matches the synthesized hardware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_work  <= '0;
         r_count <= '0;
      end else if (i_shift && !w_full) begin
         r_work  <= {r_work[OP_W-5:0], i_digit};
         r_count <= r_count + 1'b1;
      end else if (i_bksp && !w_empty) begin
         r_work  <= r_work >> 4;
         r_count <= r_count - 1'b1;
      end
   end

   assign o_work  = r_work;
   assign o_count = r_count;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: rtl/operand_entry.sv
// Keypad operand capture: digits build A then B, which are offered downstream
// on a valid/ready handshake. Optional key_err output under OPERAND_ENTRY_KEY_ERR_EN.
module operand_entry
   import calc_pkg::*;
#(
   parameter int OP_W = OP_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            key_valid,
   input  logic [4:0]      key_code,
   output logic [OP_W-1:0] a,
   output logic [OP_W-1:0] b,
   output logic            operands_valid,
   input  logic            operands_ready,
   output logic [OP_W-1:0] disp,
   output logic            entry_sel,
`ifdef OPERAND_ENTRY_KEY_ERR_EN
   output logic            key_err,
`endif
   output logic            busy
);

   localparam int NDIG  = OP_W / 4;
   localparam int CNT_W = $clog2(NDIG + 1);

   state_t           r_state;
   logic [OP_W-1:0]  r_a;
   logic [OP_W-1:0]  r_b;
   logic             r_valid;

   logic [OP_W-1:0]  w_work;
   logic [CNT_W-1:0] w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_editing;
   logic             w_clear;
   logic             w_shift;
   logic             w_bksp;
   logic             w_enter;
   logic             w_accum_clr;

   assign w_editing = (r_state != S_OUT);

   // Keys are qualified here so the accumulator only ever sees accepted edits.
   assign w_clear     = key_valid && (key_code == KEY_CLEAR);
   assign w_shift     = key_valid && key_is_digit(key_code) && w_editing && !w_full;
   assign w_bksp      = key_valid && (key_code == KEY_BKSP) && w_editing && !w_empty;
   assign w_enter     = key_valid && (key_code == KEY_ENTER) && w_editing && (w_count != '0);
   assign w_accum_clr = w_clear || w_enter;

   digit_accum #(
      .OP_W (OP_W)
   ) u_digit_accum (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_shift (w_shift),
      .i_digit (key_code[3:0]),
      .i_bksp  (w_bksp),
      .i_clear (w_accum_clr),
      .o_work  (w_work),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_A;
         r_a     <= '0;
         r_b     <= '0;
         r_valid <= 1'b0;
      end else if (w_clear) begin
         // CLEAR wins over a same-cycle handshake, so no transfer happens.
         r_state <= S_A;
         r_a     <= '0;
         r_b     <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_A: begin
               if (w_enter) begin
                  r_a     <= w_work;
                  r_state <= S_B;
               end
            end
            S_B: begin
               if (w_enter) begin
                  r_b     <= w_work;
                  r_valid <= 1'b1;
                  r_state <= S_OUT;
               end
            end
            S_OUT: begin
               if (r_valid && operands_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_A;
               end
            end
            default: begin
               r_state <= S_A;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef OPERAND_ENTRY_KEY_ERR_EN
   logic r_key_err;

   // Any pulse that is neither CLEAR nor an accepted edit/enter was rejected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_err <= 1'b0;
      end else begin
         r_key_err <= key_valid && !w_clear && !(w_shift || w_bksp || w_enter);
      end
   end

   assign key_err = r_key_err;
`endif

   assign a              = r_a;
   assign b              = r_b;
   assign operands_valid = r_valid;
   assign disp           = w_work;
   assign entry_sel      = (r_state == S_B);
   assign busy           = (r_state == S_OUT);

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry: expected operand pairs are queued when the
// second ENTER is pressed and checked when the handshake completes.
module tb_operand_entry;

   localparam logic [4:0] K_ENTER = 5'h10;
   localparam logic [4:0] K_CLEAR = 5'h11;
   localparam logic [4:0] K_BKSP  = 5'h12;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
   } pair_t;

   logic       clk;
   logic       rst_n;
   logic       key_valid;
   logic [4:0] key_code;
   logic [7:0] a;
   logic [7:0] b;
   logic       operands_valid;
   logic       operands_ready;
   logic [7:0] disp;
   logic       entry_sel;
   logic       busy;
`ifdef OPERAND_ENTRY_KEY_ERR_EN
   logic       key_err;
`endif

   int    n_cmp  = 0;
   int    n_err  = 0;
   int    n_xfer = 0;
   pair_t exp_q[$];
   pair_t exp_e;

   operand_entry #(.OP_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .key_valid      (key_valid),
      .key_code       (key_code),
      .a              (a),
      .b              (b),
      .operands_valid (operands_valid),
      .operands_ready (operands_ready),
      .disp           (disp),
      .entry_sel      (entry_sel),
`ifdef OPERAND_ENTRY_KEY_ERR_EN
      .key_err        (key_err),
`endif
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the key was sampled.
   task automatic press(input logic [4:0] code);
      key_code  = code;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      key_code  = 5'h00;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, {15'd0, operands_valid}, 16'd0);
      check({tag, "_busy"},  {15'd0, busy}, 16'd0);
      check({tag, "_sel"},   {15'd0, entry_sel}, 16'd0);
      check({tag, "_disp"},  {8'd0, disp}, 16'd0);
   endtask

   // Handshake monitor: a transfer is valid&&ready without a same-cycle CLEAR.
   always @(negedge clk) begin
      if (rst_n && operands_valid && operands_ready && !(key_valid && key_code == K_CLEAR)) begin
         n_xfer++;
         if (exp_q.size() == 0) begin
            check("xfer_unexpected", 16'd1, 16'd0);
         end else begin
            exp_e = exp_q.pop_front();
            check("xfer_a", {8'd0, a}, {8'd0, exp_e.a});
            check("xfer_b", {8'd0, b}, {8'd0, exp_e.b});
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      key_valid      = 1'b0;
      key_code       = 5'h00;
      operands_ready = 1'b0;
      #12;
      check_idle("rst");
      check("rst_a", {8'd0, a}, 16'd0);
      check("rst_b", {8'd0, b}, 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: basic A/B entry with downstream always ready
      operands_ready = 1'b1;
      press(5'h3);
      check("t1_disp3", {8'd0, disp}, 16'h03);
      press(5'hA);
      check("t1_disp3a", {8'd0, disp}, 16'h3A);
      press(K_ENTER);
      check("t1_a", {8'd0, a}, 16'h3A);
      check("t1_sel_b", {15'd0, entry_sel}, 16'd1);
      check("t1_disp0", {8'd0, disp}, 16'h00);
      press(5'h7);
      press(5'h5);
      exp_q.push_back('{a: 8'h3A, b: 8'h75});
      press(K_ENTER);
      check("t1_valid_hi", {15'd0, operands_valid}, 16'd1);
      check("t1_busy_hi", {15'd0, busy}, 16'd1);
      check("t1_b", {8'd0, b}, 16'h75);
      @(posedge clk);
      #1;
      check_idle("t1_after");
      operands_ready = 1'b0;

      // 2: third digit saturates; invalid code ignored
      press(5'h1);
      press(5'h2);
      press(5'h3);
      check("t2_sat", {8'd0, disp}, 16'h12);
`ifdef OPERAND_ENTRY_KEY_ERR_EN
      check("t2_err_hi", {15'd0, key_err}, 16'd1);
`endif
      press(5'h15);
      check("t2_invalid", {8'd0, disp}, 16'h12);
`ifdef OPERAND_ENTRY_KEY_ERR_EN
      check("t2_err_inv", {15'd0, key_err}, 16'd1);
      @(posedge clk);
      #1;
      check("t2_err_lo", {15'd0, key_err}, 16'd0);
`endif
      press(K_ENTER);
      check("t2_a", {8'd0, a}, 16'h12);
      press(K_CLEAR);
      check_idle("t2_clr");
      check("t2_clr_a", {8'd0, a}, 16'd0);

      // 3: backspace, including below empty
      press(5'h4);
      check("t3_d04", {8'd0, disp}, 16'h04);
      press(5'h9);
      check("t3_d49", {8'd0, disp}, 16'h49);
      press(K_BKSP);
      check("t3_bk1", {8'd0, disp}, 16'h04);
      press(K_BKSP);
      check("t3_bk2", {8'd0, disp}, 16'h00);
      press(K_BKSP);
      check("t3_bk3", {8'd0, disp}, 16'h00);
`ifdef OPERAND_ENTRY_KEY_ERR_EN
      check("t3_err_bk", {15'd0, key_err}, 16'd1);
`endif
      press(5'h6);
      check("t3_d06", {8'd0, disp}, 16'h06);
      press(K_ENTER);
      check("t3_a", {8'd0, a}, 16'h06);
      press(K_CLEAR);

      // 4: downstream stalls, key in S_OUT ignored, then transfer
      press(5'h1);
      press(5'h1);
      press(K_ENTER);
      press(5'h2);
      press(5'h2);
      exp_q.push_back('{a: 8'h11, b: 8'h22});
      press(K_ENTER);
      repeat (5) @(posedge clk);
      #1;
      check("t4_hold_valid", {15'd0, operands_valid}, 16'd1);
      check("t4_hold_a", {8'd0, a}, 16'h11);
      check("t4_hold_b", {8'd0, b}, 16'h22);
      press(5'h5);
      check("t4_key_ign", {8'd0, disp}, 16'h00);
      check("t4_still_busy", {15'd0, busy}, 16'd1);
`ifdef OPERAND_ENTRY_KEY_ERR_EN
      check("t4_err_out", {15'd0, key_err}, 16'd1);
`endif
      operands_ready = 1'b1;
      @(posedge clk);
      #1;
      operands_ready = 1'b0;
      check_idle("t4_after");
      check("t4_keep_a", {8'd0, a}, 16'h11);
      check("t4_keep_b", {8'd0, b}, 16'h22);

      // 5: CLEAR beats a same-cycle ready in S_OUT
      press(5'hA);
      press(K_ENTER);
      press(5'hB);
      exp_q.push_back('{a: 8'h0A, b: 8'h0B});
      press(K_ENTER);
      check("t5_valid", {15'd0, operands_valid}, 16'd1);
      operands_ready = 1'b1;
      press(K_CLEAR);
      operands_ready = 1'b0;
      void'(exp_q.pop_back());
      check_idle("t5_clr");
      check("t5_a", {8'd0, a}, 16'd0);
      check("t5_b", {8'd0, b}, 16'd0);

      // 6: asynchronous reset mid-entry
      press(5'h8);
      press(K_ENTER);
      press(5'h8);
      check("t6_pre_a", {8'd0, a}, 16'h08);
      check("t6_pre_disp", {8'd0, disp}, 16'h08);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("t6_rst");
      check("t6_rst_a", {8'd0, a}, 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      press(K_ENTER);
      check("t6_enter_ign_sel", {15'd0, entry_sel}, 16'd0);
      check("t6_enter_ign_a", {8'd0, a}, 16'd0);
`ifdef OPERAND_ENTRY_KEY_ERR_EN
      check("t6_err_enter", {15'd0, key_err}, 16'd1);
`endif

      repeat (2) @(posedge clk);
      #1;
      check("xfer_count", n_xfer[15:0], 16'd2);
      check("queue_empty", exp_q.size(), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
